// File: rtl/nmi_controller_pkg.sv
// Shared constants for the NMI controller: FSM state encoding,
// gap length between NMI pulses and the source index width.
package nmi_controller_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;
   localparam logic [1:0] ST_GAP     = 2'd3;

   localparam int GAP_CYCLES = 2;
   localparam int NMI_ID_W   = 2;

endpackage

// File: rtl/nmi_prio_enc.sv
// Combinational priority picker: returns the lowest set request index
// and a valid flag when any request bit is set.
module nmi_prio_enc
   import nmi_controller_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]  req,
   output logic [NMI_ID_W-1:0] idx,
   output logic                valid
);

   // Scanning from the top down lets the lowest set index overwrite last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = NMI_ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nmi_controller.sv
// NMI controller: captures rising edges on peripheral request lines and
// serialises them into NMI pulses with acknowledge handshake and timeout.
module nmi_controller
   import nmi_controller_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_SRC-1:0]  irq,
   input  logic [NUM_SRC-1:0]  irq_mask,
   input  logic                nmi_ack,
   input  logic                err_clr,
   output logic                nmi,
   output logic [NMI_ID_W-1:0] nmi_id,
   output logic [NUM_SRC-1:0]  pending,
   output logic                busy,
   output logic                timeout_err
);

   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

   logic [1:0]          state, state_n;
   logic                ack_meta, ack_s;
   logic [NUM_SRC-1:0]  irq_q, irq_edge;
   logic [NUM_SRC-1:0]  clr_mask, repend_mask, pending_n;
   logic [WAIT_W-1:0]   wait_cnt, wait_n;
   logic [1:0]          gap_cnt, gap_n;
   logic                nmi_n, timeout_hit;
   logic [NMI_ID_W-1:0] id_n, pick_idx;
   logic                pick_valid;

   // The acknowledge comes from the CPU clock domain, so it is brought in
   // through two flops that idle high like the line itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_meta <= 1'b1;
         ack_s    <= 1'b1;
      end else begin
         ack_meta <= nmi_ack;
         ack_s    <= ack_meta;
      end
   end

   assign irq_edge = irq & ~irq_q;
   assign busy     = (state != ST_IDLE);

   nmi_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
      .req   (pending & ~irq_mask),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Next-state logic; pending updates OR in new edges last so a capture
   // always beats a dispatch or timeout clear in the same cycle.
   always_comb begin
      state_n     = state;
      nmi_n       = nmi;
      id_n        = nmi_id;
      wait_n      = wait_cnt;
      gap_n       = gap_cnt;
      clr_mask    = '0;
      repend_mask = '0;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_n = ST_ASSERT;
               nmi_n   = 1'b1;
               id_n    = pick_idx;
               wait_n  = '0;
               for (int i = 0; i < NUM_SRC; i++) begin
                  clr_mask[i] = (pick_idx == NMI_ID_W'(i));
               end
            end
         end
         ST_ASSERT: begin
            if (!ack_s) begin
               state_n = ST_SERVICE;
               nmi_n   = 1'b0;
            end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
               state_n     = ST_GAP;
               nmi_n       = 1'b0;
               gap_n       = '0;
               timeout_hit = 1'b1;
               for (int i = 0; i < NUM_SRC; i++) begin
                  repend_mask[i] = (nmi_id == NMI_ID_W'(i));
               end
            end else begin
               wait_n = wait_cnt + 1'b1;
            end
         end
         ST_SERVICE: begin
            if (ack_s) begin
               state_n = ST_GAP;
               gap_n   = '0;
            end
         end
         ST_GAP: begin
            if (gap_cnt == 2'(GAP_CYCLES - 1)) begin
               state_n = ST_IDLE;
            end else begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            nmi_n   = 1'b0;
         end
      endcase
      pending_n = (pending & ~clr_mask) | irq_edge | repend_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         nmi      <= 1'b0;
         nmi_id   <= '0;
         pending  <= '0;
         irq_q    <= '0;
         wait_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_n;
         nmi      <= nmi_n;
         nmi_id   <= id_n;
         pending  <= pending_n;
         irq_q    <= irq;
         wait_cnt <= wait_n;
         gap_cnt  <= gap_n;
      end
   end

   // Sticky error: a timeout in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_err <= 1'b0;
      end else if (timeout_hit) begin
         timeout_err <= 1'b1;
      end else if (err_clr) begin
         timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nmi_controller.sv
// Directed bench for nmi_controller; a scoreboard queue holds the nmi_id
// expected at each NMI rising edge, popped by a negedge monitor.
module tb_nmi_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] irq = '0;
   logic [3:0] irq_mask = '0;
   logic       nmi_ack = 1'b1;
   logic       err_clr = 1'b0;
   logic       nmi;
   logic [1:0] nmi_id;
   logic [3:0] pending;
   logic       busy;
   logic       timeout_err;

   int         test_cnt = 0;
   int         fail_cnt = 0;
   logic [1:0] sb_q[$];
   logic       nmi_prev = 1'b0;

   nmi_controller #(.NUM_SRC(4), .ACK_TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .irq         (irq),
      .irq_mask    (irq_mask),
      .nmi_ack     (nmi_ack),
      .err_clr     (err_clr),
      .nmi         (nmi),
      .nmi_id      (nmi_id),
      .pending     (pending),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drop ack, let it cross the synchronizer, then return through GAP to IDLE.
   task automatic service();
      nmi_ack = 1'b0;
      tick(3);
      check_output("svc_nmi_low", nmi, 1'b0);
      nmi_ack = 1'b1;
      tick(5);
      check_output("svc_idle", busy, 1'b0);
   endtask

   // Every NMI rise must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && nmi && !nmi_prev) begin
         if (sb_q.size() == 0) begin
            check_output("sb_unexpected_nmi", {30'd0, nmi_id}, 32'hFFFF_FFFF);
         end else begin
            check_output("sb_nmi_id", {30'd0, nmi_id}, {30'd0, sb_q.pop_front()});
         end
      end
      nmi_prev = nmi;
   end

   initial begin
      tick(3);
      check_output("rst_nmi", nmi, 1'b0);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_pending", pending, 4'b0000);
      check_output("rst_err", timeout_err, 1'b0);
      check_output("rst_id", nmi_id, 2'd0);
      reset = 1'b0;
      tick(2);

      // Single request on source 2
      irq = 4'b0100;
      sb_q.push_back(2'd2);
      tick(1);
      check_output("single_pend", pending, 4'b0100);
      check_output("single_nmi_early", nmi, 1'b0);
      tick(1);
      check_output("single_nmi", nmi, 1'b1);
      check_output("single_id", nmi_id, 2'd2);
      check_output("single_pend_clr", pending, 4'b0000);
      irq = 4'b0000;
      nmi_ack = 1'b0;
      tick(2);
      check_output("single_nmi_hold", nmi, 1'b1);
      tick(1);
      check_output("single_nmi_drop", nmi, 1'b0);
      tick(3);
      nmi_ack = 1'b1;
      tick(4);
      check_output("single_gap_busy", busy, 1'b1);
      tick(1);
      check_output("single_done", busy, 1'b0);

      // Priority: sources 1 and 3 together
      irq = 4'b1010;
      sb_q.push_back(2'd1);
      sb_q.push_back(2'd3);
      tick(2);
      check_output("prio_id1", nmi_id, 2'd1);
      check_output("prio_pend", pending, 4'b1000);
      irq = 4'b0000;
      service();
      tick(1);
      check_output("prio_nmi2", nmi, 1'b1);
      check_output("prio_id3", nmi_id, 2'd3);
      service();

      // Masked source stays pending until unmasked
      irq_mask = 4'b0001;
      irq = 4'b0001;
      tick(2);
      check_output("mask_pend", pending, 4'b0001);
      tick(3);
      check_output("mask_nmi_low", nmi, 1'b0);
      irq_mask = 4'b0000;
      sb_q.push_back(2'd0);
      tick(1);
      check_output("unmask_nmi", nmi, 1'b1);
      check_output("unmask_id", nmi_id, 2'd0);
      irq = 4'b0000;
      service();

      // Acknowledge timeout with redispatch
      irq = 4'b0100;
      sb_q.push_back(2'd2);
      sb_q.push_back(2'd2);
      tick(2);
      check_output("to_nmi", nmi, 1'b1);
      irq = 4'b0000;
      tick(7);
      check_output("to_nmi_hold", nmi, 1'b1);
      tick(1);
      check_output("to_nmi_drop", nmi, 1'b0);
      check_output("to_err", timeout_err, 1'b1);
      check_output("to_repend", pending, 4'b0100);
      check_output("to_busy", busy, 1'b1);
      tick(3);
      check_output("to_redispatch", nmi, 1'b1);
      check_output("to_redispatch_id", nmi_id, 2'd2);
      service();
      check_output("to_err_sticky", timeout_err, 1'b1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check_output("to_err_clr", timeout_err, 1'b0);

      // Set-vs-clear race on source 1
      irq_mask = 4'b0010;
      irq = 4'b0010;
      tick(1);
      irq = 4'b0000;
      tick(1);
      check_output("race_prepend", pending, 4'b0010);
      irq = 4'b0010;
      irq_mask = 4'b0000;
      sb_q.push_back(2'd1);
      sb_q.push_back(2'd1);
      tick(1);
      check_output("race_nmi", nmi, 1'b1);
      check_output("race_pend", pending, 4'b0010);
      irq = 4'b0000;
      service();
      tick(1);
      check_output("race_redispatch", nmi_id, 2'd1);
      check_output("race_pend_clr", pending, 4'b0000);
      service();

      // Reset during SERVICE discards everything
      irq_mask = 4'b0001;
      irq = 4'b1001;
      sb_q.push_back(2'd3);
      tick(2);
      check_output("rmid_id", nmi_id, 2'd3);
      irq = 4'b0000;
      nmi_ack = 1'b0;
      tick(3);
      check_output("rmid_service", busy, 1'b1);
      check_output("rmid_pend_pre", pending, 4'b0001);
      reset = 1'b1;
      #1;
      check_output("rmid_nmi", nmi, 1'b0);
      check_output("rmid_busy", busy, 1'b0);
      check_output("rmid_pend", pending, 4'b0000);
      nmi_ack = 1'b1;
      irq_mask = 4'b0000;
      tick(1);
      reset = 1'b0;
      tick(10);
      check_output("rmid_no_redispatch", busy, 1'b0);

      // irq already high at reset release counts as an edge
      reset = 1'b1;
      irq = 4'b0100;
      tick(1);
      reset = 1'b0;
      sb_q.push_back(2'd2);
      tick(1);
      check_output("rel_pend", pending, 4'b0100);
      tick(1);
      check_output("rel_nmi", nmi, 1'b1);
      irq = 4'b0000;
      service();

      tick(2);
      check_output("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
